// File: rtl/q_time_dispatcher_if.sv
// FIFO read port and trigger bus between q_time_dispatcher and its neighbours.
interface q_time_dispatcher_if #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned CH_WIDTH   = 4
);
    localparam int unsigned NUM_CH = 1 << CH_WIDTH;

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  trig_valid;
    logic [CH_WIDTH-1:0]   trig_ch;
    logic [NUM_CH-1:0]     trig_onehot;

    // Dispatcher side: reads the FIFO and drives triggers.
    modport master (
        output fifo_rd_en,
        output trig_valid,
        output trig_ch,
        output trig_onehot,
        input  fifo_data,
        input  fifo_empty
    );

    // FIFO / sequencer side.
    modport slave (
        input  fifo_rd_en,
        input  trig_valid,
        input  trig_ch,
        input  trig_onehot,
        output fifo_data,
        output fifo_empty
    );
endinterface

// File: rtl/q_time_dispatcher.sv
// Turns {channel, delay} entries from the time FIFO into cycle-exact trigger
// pulses. A one-entry prefetch slot plus a bypass from the FIFO read data let
// gap-1 entries issue back to back.
module q_time_dispatcher #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned CH_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    q_time_dispatcher_if.master   bus,
    output logic                  busy,
    output logic                  underrun,
    output logic [15:0]           fire_count
);
    localparam int unsigned DLY_WIDTH = DATA_WIDTH - CH_WIDTH;
    localparam int unsigned NUM_CH    = 1 << CH_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_COUNT = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [DLY_WIDTH-1:0]  cnt;           // cycles left until the pulse, as seen next cycle
    logic [CH_WIDTH-1:0]   ch_reg;
    logic                  slot_valid, slot_valid_n;
    logic [DATA_WIDTH-1:0] slot_data, slot_data_n;
    logic                  pf_inflight;   // prefetch read issued last cycle, data lands now
    logic                  trig_q;
    logic [CH_WIDTH-1:0]   trig_ch_q;
    logic [NUM_CH-1:0]     onehot_q;
    logic                  run_fired;

    logic                  rd_en_c;
    logic                  fire_c;
    logic                  capture_load_c;
    logic                  succ_avail_c;
    logic [DATA_WIDTH-1:0] succ_data_c;
    logic                  consume_slot_c;
    logic                  consume_byp_c;
    logic [CH_WIDTH-1:0]   cur_ch_c;
    logic [DLY_WIDTH-1:0]  cur_rem_c;
    logic                  start_ok_c;

    // Effective gap of an entry: a zero delay still costs one cycle.
    function automatic logic [DLY_WIDTH-1:0] gap_of(input logic [DATA_WIDTH-1:0] e);
        logic [DLY_WIDTH-1:0] d;
        d = e[DLY_WIDTH-1:0];
        return (d == '0) ? DLY_WIDTH'(1) : d;
    endfunction

    function automatic logic [CH_WIDTH-1:0] ch_of(input logic [DATA_WIDTH-1:0] e);
        return e[DATA_WIDTH-1:DLY_WIDTH];
    endfunction

    assign start_ok_c = (state == S_IDLE) && start && !abort;

    // Next state, FIFO reads, successor selection and fire decision.
    always_comb begin
        state_n        = state;
        rd_en_c        = 1'b0;
        fire_c         = 1'b0;
        capture_load_c = 1'b0;
        consume_slot_c = 1'b0;
        consume_byp_c  = 1'b0;
        cur_ch_c       = ch_reg;
        cur_rem_c      = cnt;
        slot_valid_n   = slot_valid;
        slot_data_n    = slot_data;
        succ_avail_c   = slot_valid || pf_inflight;
        succ_data_c    = slot_valid ? slot_data : bus.fifo_data;

        case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (!bus.fifo_empty) begin
                    rd_en_c = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                capture_load_c = 1'b1;
                cur_ch_c       = ch_of(bus.fifo_data);
                cur_rem_c      = gap_of(bus.fifo_data);
                fire_c         = (cur_rem_c == DLY_WIDTH'(1));
                rd_en_c        = !bus.fifo_empty;
                state_n        = S_COUNT;
            end
            S_COUNT: begin
                // trig_q marks the cycle the pulse is on the bus: take the successor now.
                if (trig_q) begin
                    if (succ_avail_c) begin
                        cur_ch_c       = ch_of(succ_data_c);
                        cur_rem_c      = gap_of(succ_data_c);
                        consume_slot_c = slot_valid;
                        consume_byp_c  = !slot_valid;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
                if (pf_inflight && !consume_byp_c) begin
                    slot_valid_n = 1'b1;
                    slot_data_n  = bus.fifo_data;
                end else if (consume_slot_c) begin
                    slot_valid_n = 1'b0;
                end
                fire_c  = (state_n == S_COUNT) && (cur_rem_c == DLY_WIDTH'(1));
                rd_en_c = !bus.fifo_empty && !slot_valid_n && (state_n == S_COUNT);
            end
            default: state_n = S_IDLE;
        endcase

        if (abort) begin
            state_n        = S_IDLE;
            rd_en_c        = 1'b0;
            fire_c         = 1'b0;
            capture_load_c = 1'b0;
            slot_valid_n   = 1'b0;
        end
        if (reset) rd_en_c = 1'b0;
    end

    // State, entry registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ch_reg      <= '0;
            slot_valid  <= 1'b0;
            slot_data   <= '0;
            pf_inflight <= 1'b0;
            trig_q      <= 1'b0;
            trig_ch_q   <= '0;
            onehot_q    <= '0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
            fire_count  <= '0;
            run_fired   <= 1'b0;
        end else begin
            state       <= state_n;
            slot_valid  <= slot_valid_n;
            slot_data   <= slot_data_n;
            pf_inflight <= rd_en_c && ((state == S_LOAD) || (state == S_COUNT));
            busy        <= (state_n != S_IDLE);
            trig_q      <= fire_c;
            onehot_q    <= fire_c ? (NUM_CH'(1) << cur_ch_c) : '0;
            if (fire_c) trig_ch_q <= cur_ch_c;
            if ((state == S_LOAD) || (state == S_COUNT)) begin
                cnt    <= cur_rem_c - DLY_WIDTH'(1);
                ch_reg <= cur_ch_c;
            end
            if (start_ok_c) begin
                fire_count <= '0;
                underrun   <= 1'b0;
                run_fired  <= 1'b0;
            end else begin
                if (trig_q && !abort) begin
                    fire_count <= fire_count + 16'd1;
                    run_fired  <= 1'b1;
                end
                if (capture_load_c && run_fired) underrun <= 1'b1;
            end
        end
    end

    // An abort in the pulse cycle suppresses the pulse that is already on the bus.
    assign bus.fifo_rd_en  = rd_en_c;
    assign bus.trig_valid  = trig_q && !abort;
    assign bus.trig_ch     = trig_ch_q;
    assign bus.trig_onehot = onehot_q & {NUM_CH{!abort}};
endmodule

// File: tb/tb_q_time_dispatcher.sv
// Directed bench for q_time_dispatcher with a registered-read FIFO model.
module tb_q_time_dispatcher;
    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        busy;
    logic        underrun;
    logic [15:0] fire_count;

    q_time_dispatcher_if #(.DATA_WIDTH(20), .CH_WIDTH(4)) bus ();

    q_time_dispatcher #(.DATA_WIDTH(20), .CH_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .underrun   (underrun),
        .fire_count (fire_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_empty_cnt = 0;

    logic [19:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    int          trig_t [$];
    logic [3:0]  trig_c [$];
    logic [15:0] trig_o [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data registered one cycle after an accepted read.
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_data <= mem[rd_ptr % 64];
            rd_ptr        <= rd_ptr + 1;
        end
        if (bus.fifo_rd_en && bus.fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] ch, input logic [15:0] dly);
        mem[wr_ptr % 64] = {ch, dly};
        wr_ptr++;
    endtask

    task automatic start_pulse(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic abort_pulse();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic collect(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.trig_valid) begin
                trig_t.push_back(cyc - base);
                trig_c.push_back(bus.trig_ch);
                trig_o.push_back(bus.trig_onehot);
            end
        end
    endtask

    task automatic clear_log();
        trig_t.delete();
        trig_c.delete();
        trig_o.delete();
    endtask

    task automatic check_log(input string tag, input int n, input int exp_t [16], input logic [3:0] exp_c [16]);
        logic [15:0] one;
        check({tag, "_count"}, 32'(trig_t.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            one = 16'd1 << exp_c[i];
            if (i < trig_t.size()) begin
                check({tag, "_time"}, 32'(trig_t[i]), 32'(exp_t[i]));
                check({tag, "_ch"}, 32'(trig_c[i]), 32'(exp_c[i]));
                check({tag, "_onehot"}, 32'(trig_o[i]), 32'(one));
            end else begin
                check({tag, "_missing"}, 32'hFFFF_FFFF, 32'(exp_t[i]));
            end
        end
    endtask

    initial begin
        int s;
        int p;
        int et [16];
        logic [3:0] ec [16];

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick(); tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trig_valid", 32'(bus.trig_valid), 32'd0);
        check("rst_trig_ch", 32'(bus.trig_ch), 32'd0);
        check("rst_onehot", 32'(bus.trig_onehot), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_fire_count", 32'(fire_count), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        reset = 1'b0;
        tick();

        // Single entry ch 3 dly 5
        push(4'd3, 16'd5);
        start_pulse(s);
        check("t1_rd_en_s1", 32'(bus.fifo_rd_en), 32'd1);
        clear_log();
        collect(8, s);
        et[0] = 7; ec[0] = 4'd3;
        check_log("t1", 1, et, ec);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_underrun", 32'(underrun), 32'd0);
        check("t1_fire_count", 32'(fire_count), 32'd1);
        check("t1_rd_en_idle", 32'(bus.fifo_rd_en), 32'd0);
        abort_pulse();
        check("t1_abort_busy", 32'(busy), 32'd0);

        // Eight back-to-back gap-1 entries
        for (int i = 0; i < 8; i++) push(4'(i), 16'd1);
        start_pulse(s);
        clear_log();
        collect(12, s);
        for (int i = 0; i < 8; i++) begin
            et[i] = 3 + i;
            ec[i] = 4'(i);
        end
        check_log("t2", 8, et, ec);
        check("t2_fire_count", 32'(fire_count), 32'd8);
        check("t2_underrun", 32'(underrun), 32'd0);
        abort_pulse();

        // Gaps 4, 0, 10; a start mid-run is ignored
        push(4'd1, 16'd4);
        push(4'd2, 16'd0);
        push(4'd1, 16'd10);
        start_pulse(s);
        clear_log();
        collect(9, s);
        check("t3_fc_before_start", 32'(fire_count), 32'd2);
        start = 1'b1;
        collect(1, s);
        start = 1'b0;
        collect(10, s);
        et[0] = 6;  ec[0] = 4'd1;
        et[1] = 7;  ec[1] = 4'd2;
        et[2] = 17; ec[2] = 4'd1;
        check_log("t3", 3, et, ec);
        check("t3_fire_count", 32'(fire_count), 32'd3);
        abort_pulse();

        // Late second entry sets underrun, gap counts from its load
        push(4'd5, 16'd2);
        start_pulse(s);
        clear_log();
        collect(9, s);
        et[0] = 4; ec[0] = 4'd5;
        check_log("t4a", 1, et, ec);
        check("t4_underrun_early", 32'(underrun), 32'd0);
        for (int i = 0; i < 14; i++) tick();
        p = cyc;
        push(4'd6, 16'd3);
        clear_log();
        collect(8, p);
        et[0] = 4; ec[0] = 4'd6;
        check_log("t4b", 1, et, ec);
        check("t4_underrun_set", 32'(underrun), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("t4_underrun_sticky", 32'(underrun), 32'd1);
        abort_pulse();
        check("t4_underrun_abort", 32'(underrun), 32'd1);
        check("t4_fire_count_abort", 32'(fire_count), 32'd2);

        // Abort one cycle before a scheduled fire
        push(4'd7, 16'd6);
        push(4'd8, 16'd1);
        push(4'd9, 16'd1);
        start_pulse(s);
        check("t5_underrun_cleared", 32'(underrun), 32'd0);
        check("t5_fc_cleared", 32'(fire_count), 32'd0);
        clear_log();
        collect(6, s);
        check("t5_no_early_trig", 32'(trig_t.size()), 32'd0);
        abort = 1'b1;
        check("t5_abort_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("t5_abort_cycle_trig", 32'(bus.trig_valid), 32'd0);
        tick();
        abort = 1'b0;
        check("t5_trig_after", 32'(bus.trig_valid), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);
        clear_log();
        collect(5, s);
        check("t5_no_pulse", 32'(trig_t.size()), 32'd0);
        check("t5_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        check("t5_fire_count", 32'(fire_count), 32'd0);
        start_pulse(s);
        clear_log();
        collect(5, s);
        et[0] = 3; ec[0] = 4'd9;
        check_log("t5r", 1, et, ec);
        check("t5r_fire_count", 32'(fire_count), 32'd1);
        check("t5r_underrun", 32'(underrun), 32'd0);

        // Reset in the middle of COUNT
        push(4'd10, 16'd8);
        start_pulse(s);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_trig_valid", 32'(bus.trig_valid), 32'd0);
        check("t6_trig_ch", 32'(bus.trig_ch), 32'd0);
        check("t6_onehot", 32'(bus.trig_onehot), 32'd0);
        check("t6_underrun", 32'(underrun), 32'd0);
        check("t6_fire_count", 32'(fire_count), 32'd0);
        check("t6_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        reset = 1'b0;
        clear_log();
        collect(10, s);
        check("t6_no_pulse", 32'(trig_t.size()), 32'd0);
        check("rd_while_empty", 32'(rd_empty_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/q_time_dispatcher.md
# q_time_dispatcher

Consumes timing entries from the `q_time_manager` FIFO and turns each into a cycle-exact trigger pulse on one of up to 16 output channels. Each entry carries a channel index and a relative delay: cycles since the previous trigger, or since capture for the first entry of a run. A one-entry prefetch slot and a read-data bypass let entries issue back-to-back at the FIFO's registered-read latency without losing cycles. The block sits directly downstream of the time FIFO and drives the pulse/readout sequencers.

## Interface
- `DATA_WIDTH`, 20, entry width; must match the FIFO.
- `CH_WIDTH`, 4, channel field width; `NUM_CH = 2**CH_WIDTH`.
- `DLY_WIDTH`, `DATA_WIDTH-CH_WIDTH` (16), delay field width.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a run from IDLE and is ignored elsewhere.
- `abort`  in  1  one-cycle pulse; ends a run and returns to IDLE. Takes priority over everything.
- `fifo_rd_en`  out  1  read strobe to the FIFO.
- `fifo_data`  in  DATA_WIDTH  FIFO registered output, valid the cycle after an accepted read.
- `fifo_empty`  in  1  FIFO empty flag.
- `trig_valid`  out  1  one-cycle trigger pulse.
- `trig_ch`  out  CH_WIDTH  channel of the current trigger; holds its last value otherwise.
- `trig_onehot`  out  NUM_CH  one-hot of `trig_ch`, qualified by `trig_valid` (all zero otherwise).
- `busy`  out  1  high in every state except IDLE.
- `underrun`  out  1  sticky late-entry flag; cleared by `start` or `reset`.
- `fire_count`  out  16  triggers issued since the last `start`; wraps at 2^16.

## Operation
- Entry format: `[DATA_WIDTH-1:DLY_WIDTH]` = channel, `[DLY_WIDTH-1:0]` = delay. Effective gap = max(delay, 1).
- States:
  - IDLE: outputs inactive.
  - FETCH: assert `fifo_rd_en` when `!fifo_empty`. Stay in FETCH while the FIFO is empty.
  - LOAD: capture `fifo_data` into the current-entry counter and channel register.
  - COUNT: count down and fire.
- Transitions:
  - IDLE -> FETCH on `start`.
  - FETCH -> LOAD the cycle after an accepted read.
  - LOAD -> COUNT.
  - COUNT -> COUNT on a fire with a successor available.
  - COUNT -> FETCH on a fire with no successor.
  - Any state -> IDLE on `abort` or `reset`.
- Fire: if an entry is captured in cycle C, `trig_valid` is high in cycle C+gap.
- Successor rule at a fire in cycle F:
  - If the prefetch slot is valid, load it; the next fire is at F+gap_next.
  - Else if a prefetch read was issued in F-1, load directly from `fifo_data` (bypass), with the same timing.
  - Otherwise go to FETCH.
- Prefetch: in COUNT, assert `fifo_rd_en` when `!fifo_empty`, no read is in flight, and the slot is empty or is being consumed this cycle.
  - Never assert `fifo_rd_en` while `fifo_empty` is high.
  - At most one read is in flight.
- Underrun: an entry captured in LOAD after at least one fire in the current run sets `underrun`. That entry's gap counts from its capture cycle.
- `abort`:
  - Discards the current entry, the prefetch slot and any in-flight read data. FIFO contents are not drained.
  - No `trig_valid` in the abort cycle or after it.
  - `fire_count` and `underrun` hold their values.
- `start` clears `fire_count` and `underrun`.
- Reset values: state IDLE; `fifo_rd_en`=0, `trig_valid`=0, `trig_ch`=0, `trig_onehot`=0, `busy`=0, `underrun`=0, `fire_count`=0; prefetch slot invalid.

## Timing
- Read latency: 1 cycle (`fifo_rd_en` in cycle N, data in N+1).
- First trigger after `start` in cycle S with a non-empty FIFO:
  - S+1: FETCH, read issued.
  - S+2: LOAD, entry captured.
  - S+2+gap: fire.
- Sustained throughput: one trigger per gap cycles, gap ≥ 1, with no drift, as long as the FIFO stays non-empty.
- `trig_valid`, `trig_ch` and `trig_onehot` are registered and change in the same cycle.
- `fire_count` increments in the fire cycle and is visible from the following cycle.
- `abort` coincident with a fire: the abort wins and no pulse is issued.
- `start` while busy: ignored.

## Test plan
- Reset, then `start` with FIFO = {ch 3, dly 5}:
  - `fifo_rd_en` at S+1, `trig_valid` at S+7, `trig_onehot` = 0x0008.
  - Then state FETCH, `busy` = 1, `underrun` = 0.
- FIFO preloaded with 8 entries of dly 1 on ch 0..7: triggers on 8 consecutive cycles starting S+3, `fire_count` = 8, `underrun` = 0.
- Gaps {4, 0, 10} on ch {1, 2, 1}: fires at S+6, S+7, S+17 (delay 0 treated as 1).
- One entry dly 2, then a second entry pushed 20 cycles later:
  - Second entry's gap counts from its LOAD cycle.
  - `underrun` = 1 and stays set until the next `start`.
- `abort` one cycle before a scheduled fire:
  - No pulse, `busy` = 0 the next cycle.
  - Remaining FIFO entries stay untouched (`fifo_rd_en` = 0).
  - A following `start` replays from the next FIFO entry.
- `reset` asserted mid-COUNT: all outputs return to reset values the next cycle, and no read is issued while `fifo_empty` = 1.
